multicycle_main_control: RTL

- Main control FSM for the multicycle RV32 subset core (R-type add/sub/and/or, lw, sw, beq).
- Sequences the shared ALU, register file, IR/PC registers and unified memory through the fetch/decode/execute/memory/writeback steps.
- Generates the 2-bit ALU_OP consumed by the ALU control decoder, plus all datapath enables and mux selects.
- Stalls on a memory ready handshake and counts retired instructions.

---
 rtl/multicycle_main_control_pkg.sv | 35 +++
 rtl/multicycle_main_control.sv | 137 +++++++++++++
 2 files changed

// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle RV32 subset main control FSM:
// state enum, opcodes and datapath select/ALU_OP codes.
package multicycle_main_control_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_BREG = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32 subset core: sequences fetch,
// decode, execute, memory and writeback, and counts retired instructions.
module multicycle_main_control
   import multicycle_main_control_pkg::*;
#(
   parameter int width_instruc = 32,
   parameter int width_count   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [width_instruc-1:0] instruccion,
   input  logic                     zero,
   input  logic                     mem_ready,
   output logic                     pc_en,
   output logic                     i_or_d,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic                     ir_write,
   output logic                     mem_to_reg,
   output logic                     reg_write,
   output logic                     alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic [1:0]               ALU_OP,
   output logic [1:0]               pc_source,
   output logic                     illegal_op,
   output logic [width_count-1:0]   instr_count
);

   state_t                 state_q, state_d;
   logic [width_count-1:0] instr_count_q, instr_count_d;
   logic [6:0]             opcode;
   logic                   retire;
   logic                   instr_unused;

   assign opcode       = instruccion[6:0];
   assign instr_unused = ^instruccion[width_instruc-1:7];
   assign instr_count  = instr_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_BREG;
      ALU_OP     = ALUOP_ADD;
      pc_source  = PCSRC_ALU;
      illegal_op = 1'b0;
      retire     = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // IR and PC only advance on the cycle the fetch completes
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = SRCB_BOFF;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_RTYPE:          state_d = S_EXECUTE;
               OP_BRANCH:         state_d = S_BRANCH;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            ALU_OP    = ALUOP_FUNCT;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            ALU_OP    = ALUOP_SUB;
            pc_source = PCSRC_ALUOUT;
            pc_en     = zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      instr_count_d = instr_count_q + width_count'(retire);
   end

endmodule
